// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALU control codes, ALUOp classes, R-type Funct codes
// and the EX-stage control bundle.
package alu_pkg;

    localparam int unsigned ALU_CTRL_W = 4;
    localparam int unsigned ALU_OP_W   = 2;
    localparam int unsigned FUNCT_W    = 6;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_SLT = 4'b0100,
        ALU_NOP = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_AND   = 2'b11
    } alu_op_e;

    typedef enum logic [FUNCT_W-1:0] {
        FUNCT_ADD = 6'b100000,
        FUNCT_SUB = 6'b100010,
        FUNCT_AND = 6'b100100,
        FUNCT_OR  = 6'b100101,
        FUNCT_SLT = 6'b101010
    } funct_e;

    typedef struct packed {
        logic reg_dst;
        logic alu_src;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } ex_ctrl_t;

endpackage

// File: rtl/alu_ctrl.sv
// ALU control decode from the registered ALUOp class and Funct field;
// an invalid (bubble) slot always decodes to NOP.
module alu_ctrl
    import alu_pkg::*;
(
    input  logic                  valid,
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic [FUNCT_W-1:0]    funct,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_c
);

    always_comb begin
        alu_ctrl_c = ALU_NOP;
        if (valid) begin
            case (alu_op)
                ALUOP_ADD: alu_ctrl_c = ALU_ADD;
                ALUOP_SUB: alu_ctrl_c = ALU_SUB;
                ALUOP_AND: alu_ctrl_c = ALU_AND;
                default: begin
                    case (funct)
                        FUNCT_ADD: alu_ctrl_c = ALU_ADD;
                        FUNCT_SUB: alu_ctrl_c = ALU_SUB;
                        FUNCT_AND: alu_ctrl_c = ALU_AND;
                        FUNCT_OR:  alu_ctrl_c = ALU_OR;
                        FUNCT_SLT: alu_ctrl_c = ALU_SLT;
                        default:   alu_ctrl_c = ALU_NOP;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, ALU control decode and operand
// selection. Define FORWARD_EN to build the EX/MEM and MEM/WB forwarding muxes.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic [DW-1:0]         ReadData1In,
    input  logic [DW-1:0]         ReadData2In,
    input  logic [DW-1:0]         SignExtImm,
    input  logic [RW-1:0]         Rs,
    input  logic [RW-1:0]         Rt,
    input  logic [RW-1:0]         Rd,
    input  logic                  RegDst,
    input  logic                  ALUSrc,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  MemtoReg,
    input  logic                  RegWrite,
    input  logic [ALU_OP_W-1:0]   ALUOp,
    input  logic [FUNCT_W-1:0]    Funct,
    input  logic                  ExMemRegWrite,
    input  logic [RW-1:0]         ExMemRd,
    input  logic [DW-1:0]         ExMemResult,
    input  logic                  MemWbRegWrite,
    input  logic [RW-1:0]         MemWbRd,
    input  logic [DW-1:0]         MemWbData,
    output logic [DW-1:0]         ReadData1,
    output logic [DW-1:0]         ReadData2,
    output logic [ALU_CTRL_W-1:0] ALUcontrol,
    output logic [DW-1:0]         StoreData,
    output logic [RW-1:0]         WriteReg,
    output logic                  Valid,
    output logic                  MemReadEx,
    output logic                  MemWriteEx,
    output logic                  MemtoRegEx,
    output logic                  RegWriteEx
);

    logic                valid_q,  valid_d;
    ex_ctrl_t            ctrl_q,   ctrl_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic [FUNCT_W-1:0]  funct_q,  funct_d;
    logic [DW-1:0]       rd1_q,    rd1_d;
    logic [DW-1:0]       rd2_q,    rd2_d;
    logic [DW-1:0]       imm_q,    imm_d;
    logic [RW-1:0]       rs_q,     rs_d;
    logic [RW-1:0]       rt_q,     rt_d;
    logic [RW-1:0]       rd_q,     rd_d;
    logic [DW-1:0]       op_a,     op_b;

    // Flush wins over stall and loads an all-zero bubble
    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        alu_op_d = alu_op_q;
        funct_d  = funct_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        if (Flush) begin
            valid_d  = 1'b0;
            ctrl_d   = '0;
            alu_op_d = '0;
            funct_d  = '0;
            rd1_d    = '0;
            rd2_d    = '0;
            imm_d    = '0;
            rs_d     = '0;
            rt_d     = '0;
            rd_d     = '0;
        end else if (!Stall) begin
            valid_d           = 1'b1;
            ctrl_d.reg_dst    = RegDst;
            ctrl_d.alu_src    = ALUSrc;
            ctrl_d.mem_read   = MemRead;
            ctrl_d.mem_write  = MemWrite;
            ctrl_d.mem_to_reg = MemtoReg;
            ctrl_d.reg_write  = RegWrite;
            alu_op_d          = ALUOp;
            funct_d           = Funct;
            rd1_d             = ReadData1In;
            rd2_d             = ReadData2In;
            imm_d             = SignExtImm;
            rs_d              = Rs;
            rt_d              = Rt;
            rd_d              = Rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            alu_op_q <= '0;
            funct_q  <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            alu_op_q <= alu_op_d;
            funct_q  <= funct_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
        end
    end

`ifdef FORWARD_EN
    // EX/MEM has priority; register 0 is never a forwarding target
    always_comb begin
        op_a = rd1_q;
        op_b = rd2_q;
        if (ExMemRegWrite && (ExMemRd != '0) && (ExMemRd == rs_q)) begin
            op_a = ExMemResult;
        end else if (MemWbRegWrite && (MemWbRd != '0) && (MemWbRd == rs_q)) begin
            op_a = MemWbData;
        end
        if (ExMemRegWrite && (ExMemRd != '0) && (ExMemRd == rt_q)) begin
            op_b = ExMemResult;
        end else if (MemWbRegWrite && (MemWbRd != '0) && (MemWbRd == rt_q)) begin
            op_b = MemWbData;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ExMemRegWrite, ExMemRd, ExMemResult,
                          MemWbRegWrite, MemWbRd, MemWbData, rs_q};

    always_comb begin
        op_a = rd1_q;
        op_b = rd2_q;
    end
`endif

    alu_ctrl u_alu_ctrl (
        .valid      (valid_q),
        .alu_op     (alu_op_q),
        .funct      (funct_q),
        .alu_ctrl_c (ALUcontrol)
    );

    assign ReadData1  = op_a;
    assign ReadData2  = ctrl_q.alu_src ? imm_q : op_b;
    assign StoreData  = op_b;
    assign WriteReg   = ctrl_q.reg_dst ? rd_q : rt_q;
    assign Valid      = valid_q;
    assign MemReadEx  = ctrl_q.mem_read;
    assign MemWriteEx = ctrl_q.mem_write;
    assign MemtoRegEx = ctrl_q.mem_to_reg;
    assign RegWriteEx = ctrl_q.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues hand-computed EX-stage
// outputs each cycle, a monitor pops and compares them on the falling edge.
module tb_id_ex_stage;
    import alu_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Stall, Flush;
    logic [DW-1:0] ReadData1In, ReadData2In, SignExtImm;
    logic [RW-1:0] Rs, Rt, Rd;
    logic          RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite;
    logic [1:0]    ALUOp;
    logic [5:0]    Funct;
    logic          ExMemRegWrite, MemWbRegWrite;
    logic [RW-1:0] ExMemRd, MemWbRd;
    logic [DW-1:0] ExMemResult, MemWbData;
    logic [DW-1:0] ReadData1, ReadData2, StoreData;
    logic [3:0]    ALUcontrol;
    logic [RW-1:0] WriteReg;
    logic          Valid, MemReadEx, MemWriteEx, MemtoRegEx, RegWriteEx;

    typedef struct {
        string         tag;
        logic          valid;
        logic [3:0]    alu;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] st;
        logic [RW-1:0] wr;
        logic [3:0]    ctl;   // {MemRead, MemWrite, MemtoReg, RegWrite}
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush),
        .ReadData1In(ReadData1In), .ReadData2In(ReadData2In), .SignExtImm(SignExtImm),
        .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUOp(ALUOp), .Funct(Funct),
        .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
        .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbData(MemWbData),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .ALUcontrol(ALUcontrol),
        .StoreData(StoreData), .WriteReg(WriteReg), .Valid(Valid),
        .MemReadEx(MemReadEx), .MemWriteEx(MemWriteEx), .MemtoRegEx(MemtoRegEx),
        .RegWriteEx(RegWriteEx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // ctl = {RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite}
    task automatic set_dec(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [1:0] op, input logic [5:0] fn, input logic [5:0] ctl);
        ReadData1In = rd1; ReadData2In = rd2; SignExtImm = imm;
        Rs = rs; Rt = rt; Rd = rd; ALUOp = op; Funct = fn;
        {RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite} = ctl;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mdat);
        ExMemRegWrite = ew; ExMemRd = erd; ExMemResult = eres;
        MemWbRegWrite = mw; MemWbRd = mrd; MemWbData = mdat;
    endtask

    task automatic push_exp(input string tag, input logic v, input logic [3:0] alu,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                            input logic [4:0] wr, input logic [3:0] ctl);
        exp_t e;
        e.tag = tag; e.valid = v; e.alu = alu; e.a = a; e.b = b;
        e.st = st; e.wr = wr; e.ctl = ctl;
        exp_q.push_back(e);
    endtask

    task automatic bubble(input string tag);
        push_exp(tag, 1'b0, 4'b1111, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0000);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".valid"}, 32'(Valid), 32'(e.valid));
                chk({e.tag, ".alu"}, 32'(ALUcontrol), 32'(e.alu));
                chk({e.tag, ".rd1"}, ReadData1, e.a);
                chk({e.tag, ".rd2"}, ReadData2, e.b);
                chk({e.tag, ".store"}, StoreData, e.st);
                chk({e.tag, ".wreg"}, 32'(WriteReg), 32'(e.wr));
                chk({e.tag, ".ctl"}, 32'({MemReadEx, MemWriteEx, MemtoRegEx, RegWriteEx}),
                    32'(e.ctl));
            end else if (Valid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got %b want 0", Valid);
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 6'b000000);
        set_fwd(0, 0, 0, 0, 0, 0);
        tick();

        bubble("reset");
        rst_n = 1'b1;
        set_dec(32'd5, 32'd9, 32'h1234, 5'd1, 5'd2, 5'd4, 2'b10, 6'b101010, 6'b100001);
        tick();

        push_exp("slt", 1, 4'b0100, 32'd5, 32'd9, 32'd9, 5'd4, 4'b0001);
        set_dec(32'h100, 32'h200, 0, 5'd3, 5'd6, 5'd0, 2'b10, 6'b100000, 6'b000001);
        tick();

        set_fwd(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
        push_exp("fwd_exmem", 1, 4'b0000, FWD ? 32'h11 : 32'h100, 32'h200, 32'h200, 5'd6, 4'b0001);
        set_dec(32'hDEAD, 32'hBEEF, 32'hF0F0, 5'd7, 5'd8, 5'd9, 2'b01, 6'd0, 6'b110110);
        Stall = 1'b1;
        tick();

        set_fwd(0, 5'd3, 32'h11, 1, 5'd3, 32'h22);
        push_exp("fwd_memwb", 1, 4'b0000, FWD ? 32'h22 : 32'h100, 32'h200, 32'h200, 5'd6, 4'b0001);
        tick();

        set_fwd(0, 0, 0, 0, 0, 0);
        push_exp("stall3", 1, 4'b0000, 32'h100, 32'h200, 32'h200, 5'd6, 4'b0001);
        tick();

        push_exp("stall_end", 1, 4'b0000, 32'h100, 32'h200, 32'h200, 5'd6, 4'b0001);
        Stall = 1'b0;
        set_dec(32'h33, 32'h77, 0, 5'd5, 5'd0, 5'd0, 2'b01, 6'd0, 6'b001010);
        tick();

        set_fwd(1, 5'd0, 32'h99, 1, 5'd0, 32'h88);
        push_exp("zero_reg", 1, 4'b0001, 32'h33, 32'h77, 32'h77, 5'd0, 4'b1010);
        set_dec(32'h40, 32'h50, 32'hFFFFFFFC, 5'd2, 5'd4, 5'd0, 2'b00, 6'd0, 6'b010100);
        tick();

        set_fwd(1, 5'd4, 32'h55, 1, 5'd2, 32'h66);
        push_exp("imm", 1, 4'b0000, FWD ? 32'h66 : 32'h40, 32'hFFFFFFFC,
                 FWD ? 32'h55 : 32'h50, 5'd4, 4'b0100);
        set_dec(32'd3, 32'd4, 0, 5'd1, 5'd1, 5'd31, 2'b10, 6'b100101, 6'b100101);
        Stall = 1'b1; Flush = 1'b1;
        tick();

        set_fwd(0, 0, 0, 0, 0, 0);
        bubble("flush");
        Stall = 1'b0; Flush = 1'b0;
        tick();

        push_exp("or", 1, 4'b0011, 32'd3, 32'd4, 32'd4, 5'd31, 4'b0101);
        set_dec(32'hA, 32'hB, 0, 5'd0, 5'd0, 5'd2, 2'b11, 6'd0, 6'b100001);
        tick();

        set_fwd(1, 5'd0, 32'h99, 0, 0, 0);
        push_exp("aluop11", 1, 4'b0010, 32'hA, 32'hB, 32'hB, 5'd2, 4'b0001);
        set_dec(32'd1, 32'd2, 0, 5'd0, 5'd0, 5'd0, 2'b10, 6'b100010, 6'b000000);
        tick();

        set_fwd(0, 0, 0, 0, 0, 0);
        push_exp("sub", 1, 4'b0001, 32'd1, 32'd2, 32'd2, 5'd0, 4'b0000);
        set_dec(32'd6, 32'd7, 0, 5'd0, 5'd0, 5'd0, 2'b10, 6'b100100, 6'b000000);
        tick();

        push_exp("and", 1, 4'b0010, 32'd6, 32'd7, 32'd7, 5'd0, 4'b0000);
        set_dec(32'd8, 32'd9, 0, 5'd0, 5'd0, 5'd0, 2'b10, 6'b111111, 6'b000001);
        tick();

        push_exp("bad_funct", 1, 4'b1111, 32'd8, 32'd9, 32'd9, 5'd0, 4'b0001);
        set_dec(32'd1, 32'd2, 0, 5'd0, 5'd5, 5'd9, 2'b00, 6'd0, 6'b000001);
        Stall = 1'b1;
        tick();

        // reset lands while an instruction is held by the stall
        bubble("in_reset");
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst.valid", 32'(Valid), 32'd0);
        chk("async_rst.regwrite", 32'(RegWriteEx), 32'd0);
        chk("async_rst.alu", 32'(ALUcontrol), 32'hF);
        Stall = 1'b0;
        tick();

        bubble("rst_release");
        rst_n = 1'b1;
        tick();

        push_exp("post_rst", 1, 4'b0000, 32'd1, 32'd2, 32'd2, 5'd5, 4'b0001);
        Flush = 1'b1;
        tick();

        bubble("final_flush");
        Flush = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 6'b000000);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DW, 32, datapath width; all data ports below are DW bits.
REQ-002 SHALL have parameter RW, 5, register-specifier width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports Stall, Flush  in  1 each  hold / bubble request from hazard unit.
REQ-006 SHALL have ports ReadData1In, ReadData2In, SignExtImm  in  DW  decode-stage operands and extended immediate.
REQ-007 SHALL have ports Rs, Rt, Rd  in  RW  decode-stage register specifiers.
REQ-008 SHALL have ports RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  decode controls.
REQ-009 SHALL have ports ALUOp  in  2 and Funct  in  6  ALU operation class and R-type function field.
REQ-010 SHALL have ports ExMemRegWrite  in  1, ExMemRd  in  RW, ExMemResult  in  DW  EX/MEM forwarding source.
REQ-011 SHALL have ports MemWbRegWrite  in  1, MemWbRd  in  RW, MemWbData  in  DW  MEM/WB forwarding source.
REQ-012 SHALL have ports ReadData1, ReadData2  out  DW  ALU operands; ALUcontrol  out  4  ALU opcode.
REQ-013 SHALL have ports StoreData  out  DW, WriteReg  out  RW, Valid  out  1, and MemRead/MemWrite/MemtoReg/RegWrite outputs (suffix Ex)  out  1 each.

Function
REQ-014 SHALL register all decode inputs (REQ-006..009) on each rising clk when Stall=0 and Flush=0; latency one cycle.
REQ-015 SHALL hold every register unchanged when Stall=1 and Flush=0.
REQ-016 SHALL load a bubble when Flush=1 (regardless of Stall): all control bits 0, Valid=0, data registers 0.
REQ-017 SHALL set Valid=1 on every non-stalled, non-flushed capture.
REQ-018 SHALL drive ALUcontrol combinationally from registered ALUOp/Funct: ALUOp 00->0000, 01->0001, 11->0010, 10->decode Funct.
REQ-019 SHALL decode Funct 100000->0000, 100010->0001, 100100->0010, 100101->0011, 101010->0100, any other->1111.
REQ-020 SHALL drive ALUcontrol=1111 when Valid=0.
REQ-021 SHALL drive WriteReg = registered RegDst ? Rd : Rt.
REQ-022 SHALL select operand A as: ExMemResult if ExMemRegWrite=1, ExMemRd!=0, ExMemRd==Rs; else MemWbData if MemWbRegWrite=1, MemWbRd!=0, MemWbRd==Rs; else registered ReadData1In.
REQ-023 SHALL select forwarded B identically against registered Rt; EX/MEM always wins over MEM/WB.
REQ-024 SHALL drive ReadData1 = operand A; ReadData2 = registered ALUSrc ? SignExtImm : forwarded B; StoreData = forwarded B.
REQ-025 SHALL never forward to register 0; register-0 reads pass registered value unchanged.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear all registers: Valid=0, all control outputs 0, ALUcontrol=1111, WriteReg=0, StoreData=0.
REQ-027 SHALL abandon any held (stalled) instruction on reset mid-operation; first capture after rst_n rises follows REQ-014.

Configuration
REQ-028 SHALL compile forwarding muxes (REQ-022..023) only when FORWARD_EN is defined.
REQ-029 SHALL, without FORWARD_EN, use registered ReadData1In/ReadData2In directly; forwarding ports remain present but unused.

Structure
REQ-030 SHALL take ALUcontrol codes (ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100, NOP 1111), ALUOp classes and Funct codes from shared package alu_pkg.
REQ-031 SHALL place the REQ-018..020 decode in sub-module alu_ctrl; register and forwarding logic stay in id_ex_stage.

Verification
REQ-032 Reset: rst_n=0 mid-stream -> immediately Valid=0, RegWriteEx=0, ALUcontrol=1111.
REQ-033 Decode: ALUOp=10, Funct=101010, ReadData1In=5, ReadData2In=9 -> next cycle ALUcontrol=0100, ReadData1=5, ReadData2=9.
REQ-034 Forward priority: Rs=3, ExMemRd=3/ExMemResult=0x11, MemWbRd=3/MemWbData=0x22, both RegWrite=1 -> ReadData1=0x11; ExMemRegWrite=0 -> 0x22.
REQ-035 Zero register: Rt=0, ExMemRd=0, ExMemRegWrite=1, ALUSrc=0 -> ReadData2 = registered ReadData2In, not ExMemResult.
REQ-036 Stall/Flush: Stall=1 for 3 cycles -> outputs frozen; Stall=1 with Flush=1 -> next cycle Valid=0, MemWriteEx=0, ALUcontrol=1111.
REQ-037 Immediate: ALUOp=00, ALUSrc=1, SignExtImm=0xFFFFFFFC, MemWrite=1, Rt forwarded 0x55 -> ReadData2=0xFFFFFFFC, StoreData=0x55, ALUcontrol=0000.
